control_sequencer: RTL

Registered, parametrised successor to the combinational instruction decoder. Decodes `opcode_i`/`funct_i` in the ID stage and drives the branch/hazard signals combinationally. Captures the EX-stage control bundle into its own ID/EX register, inserting bubbles on flush, stall or illegal instructions. A small FSM stretches multi-cycle `mul` over `MUL_CYCLES` clocks and back-pressures the front end.

---
 rtl/control_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Registered instruction decoder: combinational ID-stage branch/hazard controls,
// an ID/EX control register with bubble insertion, and an FSM that stretches mul.
module control_sequencer #(
  parameter int MUL_CYCLES   = 3,
  parameter bit ENABLE_SHIFT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       use_reg1_ctrl_o,
  output logic       use_reg2_ctrl_o,
  output logic       immed_ctrl_o,
  output logic [1:0] pc_mux_ctrl_o,
  output logic       flush_ctrl_o,
  output logic       reg_write_ctrl_o,
  output logic       mem_read_ctrl_o,
  output logic       mem_write_ctrl_o,
  output logic [2:0] alu_ctrl_o,
  output logic       use_shift_ctrl_o,
  output logic       use_sign_extend_ctrl_o,
  output logic       reg_write_addr2_ctrl_o,
  output logic       stall_o,
  output logic       illegal_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam int CW = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam bit MULTI_CYCLE = (MUL_CYCLES > 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;
  logic [8:0]    r_bundle;
  logic          r_illegal;

  logic       w_legal, w_regWrite, w_memRead, w_memWrite;
  logic [2:0] w_alu;
  logic       w_useShift, w_signExt, w_addr2, w_reg1, w_reg2;
  logic       w_isBeq, w_isJ, w_isMul;
  logic       w_busy, w_idGo, w_loadEn;
  logic [8:0] w_bundle;

  // Instruction decode; anything not matched leaves every field at 0.
  always_comb begin
    w_legal    = 1'b0;
    w_regWrite = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_alu      = 3'b000;
    w_useShift = 1'b0;
    w_signExt  = 1'b0;
    w_addr2    = 1'b0;
    w_reg1     = 1'b0;
    w_reg2     = 1'b0;
    w_isBeq    = 1'b0;
    w_isJ      = 1'b0;
    w_isMul    = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      case (funct_i)
        F_ADD: begin w_legal = 1'b1; w_alu = 3'b000; end
        F_SUB: begin w_legal = 1'b1; w_alu = 3'b001; end
        F_AND: begin w_legal = 1'b1; w_alu = 3'b010; end
        F_OR:  begin w_legal = 1'b1; w_alu = 3'b011; end
        F_MUL: begin w_legal = 1'b1; w_alu = 3'b100; w_isMul = 1'b1; end
        F_SLL: if (ENABLE_SHIFT) begin w_legal = 1'b1; w_alu = 3'b101; w_useShift = 1'b1; end
        F_SRL: if (ENABLE_SHIFT) begin w_legal = 1'b1; w_alu = 3'b110; w_useShift = 1'b1; end
        default: ;
      endcase
      w_regWrite = w_legal;
      w_reg2     = w_legal;
      w_reg1     = w_legal & ~w_useShift;
    end else begin
      case (opcode_i)
        OP_LW:   begin w_legal = 1'b1; w_regWrite = 1'b1; w_memRead = 1'b1;
                       w_signExt = 1'b1; w_addr2 = 1'b1; w_reg1 = 1'b1; end
        OP_SW:   begin w_legal = 1'b1; w_memWrite = 1'b1; w_signExt = 1'b1;
                       w_reg1 = 1'b1; w_reg2 = 1'b1; end
        OP_ADDI: begin w_legal = 1'b1; w_regWrite = 1'b1; w_signExt = 1'b1;
                       w_addr2 = 1'b1; w_reg1 = 1'b1; end
        OP_BEQ:  begin w_legal = 1'b1; w_reg1 = 1'b1; w_reg2 = 1'b1; w_isBeq = 1'b1; end
        OP_J:    begin w_legal = 1'b1; w_isJ = 1'b1; end
        default: ;
      endcase
    end
  end

  assign w_busy   = (r_state == MUL_BUSY);
  assign w_idGo   = valid_i & ~stall_i & ~w_busy;
  assign w_loadEn = ~w_busy & valid_i & ~stall_i & ~flush_i & w_legal;
  assign w_bundle = {w_regWrite, w_memRead, w_memWrite, w_alu, w_useShift, w_signExt, w_addr2};

  assign use_reg1_ctrl_o = valid_i & w_reg1;
  assign use_reg2_ctrl_o = valid_i & w_reg2;
  assign immed_ctrl_o    = valid_i & w_isBeq;
  assign pc_mux_ctrl_o   = (w_idGo & w_isBeq) ? 2'b01 : ((w_idGo & w_isJ) ? 2'b10 : 2'b00);
  assign flush_ctrl_o    = w_idGo & (w_isBeq | w_isJ);

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE:
        if (MULTI_CYCLE && w_loadEn && w_isMul) begin
          w_nextState = MUL_BUSY;
          w_nextCnt   = CNT_INIT;
        end
      MUL_BUSY:
        if (r_cnt == '0) w_nextState = IDLE;
        else             w_nextCnt   = r_cnt - 1'b1;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Busy holds the mul bundle so the external stall/flush cannot disturb it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bundle  <= '0;
      r_illegal <= 1'b0;
    end else if (w_busy) begin
      r_illegal <= 1'b0;
    end else if (flush_i || stall_i || !valid_i) begin
      r_bundle  <= '0;
      r_illegal <= 1'b0;
    end else if (!w_legal) begin
      r_bundle  <= '0;
      r_illegal <= 1'b1;
    end else begin
      r_bundle  <= w_bundle;
      r_illegal <= 1'b0;
    end
  end

  // Write-back only fires in the last mul cycle, once busy has dropped.
  assign reg_write_ctrl_o       = r_bundle[8] & ~w_busy;
  assign mem_read_ctrl_o        = r_bundle[7];
  assign mem_write_ctrl_o       = r_bundle[6];
  assign alu_ctrl_o             = r_bundle[5:3];
  assign use_shift_ctrl_o       = r_bundle[2];
  assign use_sign_extend_ctrl_o = r_bundle[1];
  assign reg_write_addr2_ctrl_o = r_bundle[0];
  assign stall_o                = w_busy;
  assign illegal_o              = r_illegal;

endmodule
